// File: rtl/ps2_kbd_mmio.sv
// PS/2 keyboard receiver with a scancode FIFO and a small CPU read window.
// Frames are deserialised from filtered PS/2 clock falls; the CPU pops bytes through DATA.
module ps2_kbd_mmio #(
  parameter int unsigned FIFO_AW    = 4,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 200000
) (
  input  logic        ui_clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        mmio_sel,
  input  logic        mmio_rd,
  input  logic        mmio_wr,
  input  logic [1:0]  mmio_addr,
  input  logic [31:0] mmio_wdata,
  output logic [31:0] mmio_rdata,
  output logic        kbd_irq,
  output logic [1:0]  dbg_state
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);

  localparam logic [FiltW-1:0]   FiltLast    = FiltW'(FILTER_LEN - 1);
  localparam logic [FiltW-1:0]   FiltOne     = FiltW'(1);
  localparam logic [17:0]        TimeoutLast = 18'(TIMEOUT - 1);
  localparam logic [FIFO_AW:0]   DepthCnt    = (FIFO_AW + 1)'(Depth);
  localparam logic [FIFO_AW:0]   CntOne      = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PtrOne      = FIFO_AW'(1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2,
    StStop   = 2'd3
  } state_e;

  logic unused_wdata;
  assign unused_wdata = ^mmio_wdata;

  // Input conditioning
  logic [1:0]       clk_sync_q, data_sync_q;
  logic             filt_q;
  logic [FiltW-1:0] filt_cnt_q;
  logic             clk_s, data_s, filt_done, fall;

  assign clk_s     = clk_sync_q[1];
  assign data_s    = data_sync_q[1];
  assign filt_done = (filt_cnt_q == FiltLast);
  assign fall      = filt_q & ~clk_s & filt_done;

  always_ff @(posedge ui_clk) begin
    if (!rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      if (clk_s == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_done) begin
        filt_q     <= clk_s;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FiltOne;
      end
    end
  end

  // Receiver FSM
  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [17:0] to_cnt_q, to_cnt_d;
  logic        push, set_ferr, set_perr;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_cnt_d  = fall ? 18'd0 : to_cnt_q + 18'd1;
    push      = 1'b0;
    set_ferr  = 1'b0;
    set_perr  = 1'b0;
    case (state_q)
      StIdle: begin
        to_cnt_d = '0;
        if (fall && !data_s) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (fall) begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          par_d   = data_s;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          set_ferr = ~data_s;
          set_perr = ~(^{shift_q, par_q});
          push     = data_s & (^{shift_q, par_q});
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // A stalled partial frame is dropped silently
    if (state_q != StIdle && !fall && to_cnt_q == TimeoutLast) begin
      state_d  = StIdle;
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge ui_clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // FIFO and register-side handshakes
  logic [7:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               rd_q, wr_q, rd_now, wr_now;
  logic               empty, full, pop, push_ok, ovf_set, clr;
  logic               ovf_q, perr_q, ferr_q;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DepthCnt);
  assign rd_now  = mmio_sel & mmio_rd & (mmio_addr == 2'd0);
  assign wr_now  = mmio_sel & mmio_wr & (mmio_addr == 2'd2);
  // Pop on the strobe's trailing edge so DATA holds through the whole CPU stall
  assign pop     = rd_q & ~rd_now & ~empty;
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;
  assign clr     = wr_now & ~wr_q;

  always_ff @(posedge ui_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge ui_clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      rd_q <= rd_now;
      wr_q <= wr_now;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrOne;
      if (push_ok && !pop)      count_q <= count_q + CntOne;
      else if (pop && !push_ok) count_q <= count_q - CntOne;
      ovf_q  <= (ovf_q & ~clr) | ovf_set;
      perr_q <= (perr_q & ~clr) | set_perr;
      ferr_q <= (ferr_q & ~clr) | set_ferr;
    end
  end

  always_comb begin
    mmio_rdata = '0;
    if (mmio_sel) begin
      case (mmio_addr)
        2'd0:    mmio_rdata = {23'd0, ~empty, empty ? 8'd0 : mem_q[rd_ptr_q]};
        2'd1:    mmio_rdata = {22'd0, 5'(count_q), 2'd0, ferr_q, perr_q, ovf_q};
        default: mmio_rdata = '0;
      endcase
    end
  end

  assign kbd_irq   = ~empty;
  assign dbg_state = state_q;

endmodule
